toggle_event_decoder: RTL
=========================

# toggle_event_decoder

- Receive side of the toggle-event link: a source (e.g. the key toggler) signals each event by inverting a level line.
- This block synchronizes that line into `clk`, detects every transition, and converts each into one queued event.
- Events are delivered to a consumer over a valid/ready handshake; a pending count, a running total and a sticky overflow flag are kept.
- It sits between UI/control toggle sources and the control FSMs that must not miss or double-count events.

## Interface
- SYNC_STAGES, 2, synchronizer flop count on `tog_in`; legal values ≥2.
- CNT_W, 4, width of the pending-event counter; maximum queue depth is 2^CNT_W−1.
- TOTAL_W, 16, width of the running event total.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tog_in  in  1  toggle line; asynchronous to `clk`; each level change is one event
- evt_valid  out  1  high while at least one event is pending
- evt_ready  in  1  consumer accepts one event on a cycle where `evt_valid && evt_ready`
- pending  out  CNT_W  events detected but not yet accepted
- total  out  TOTAL_W  count of all detected transitions, including dropped ones; wraps modulo 2^TOTAL_W
- overflow  out  1  sticky; an event was dropped because the queue was full
- clr_overflow  in  1  synchronous clear of `overflow`

## Operation
- Synchronizer:
  - SYNC_STAGES-deep flop chain; the last stage is `s`.
  - A further register `last` holds the previous `s`.
- Detect: `det = s ^ last`, combinational from registered values.
- Accept: `acc = evt_valid && evt_ready`.
- Pending update, per cycle:
  - `det && !acc`: +1 if `pending` < max. If `pending` == max, the event is dropped and `overflow` is set.
  - `!det && acc`: −1.
  - `det && acc`: unchanged. No drop, even when full.
  - Neither: unchanged.
- `evt_valid = (pending != 0)`, driven from the register only, with no combinational path from `evt_ready`.
- `evt_ready` is ignored while `evt_valid` is low; no underflow is possible.
- `total` increments by 1 on every `det` cycle, including dropped events, and wraps from all-ones to 0.
- `overflow`:
  - Set on a drop; cleared by `clr_overflow`.
  - If a drop and `clr_overflow` occur in the same cycle, the set wins.
- Reset:
  - All sync stages, `last`, `pending`, `total` and `overflow` go to 0, so `evt_valid` = 0.
  - If `tog_in` is high when reset releases, exactly one event is detected. This is consistent with sources that also reset low.
- Reset mid-operation discards all pending events without producing any `acc`.

## Timing
- All state updates on `posedge clk`; all outputs are registered.
- Latency: a `tog_in` change that is stable before edge 1 reaches `s` after edge SYNC_STAGES. The pending register then updates at edge SYNC_STAGES+1, and `evt_valid` rises after that edge (3 edges at default).
- Throughput: one detection and one acceptance per cycle, concurrently.
- `tog_in` must hold each level for at least 2 `clk` periods to be detected. Shorter pulses may be lost in pairs (no net edge), and that loss is not flagged.
- The handshake is level-based: the consumer may hold `evt_ready` high and drain one event per cycle. After a single event, `evt_valid` drops the cycle after acceptance.
- `pending` and `total` update in the same cycle as `det` and `acc`; no skew between them.

## Test plan
- Reset, then one toggle 0→1 of `tog_in` with `evt_ready`=0 → `evt_valid` rises 3 edges later. `pending`=1, `total`=1; no further change while idle.
- From `pending`=1, pulse `evt_ready` for 1 cycle → `pending`=0 and `evt_valid`=0 after that edge. A second toggle 1→0 → `pending`=1, `total`=2.
- `evt_ready`=0 (CNT_W=4), 16 toggles spaced 4 cycles apart → `pending` saturates at 15 and `total`=16. `overflow`=1 after the 16th detection; `clr_overflow` pulse → 0.
- `pending`=15, `evt_ready` held 1 while a toggle arrives → on the `det && acc` cycle `pending` stays 15 and `overflow` stays 0. With ready held and no further toggles, the queue drains to 0 in 15 cycles.
- `total` preset by 65535 toggles (TOTAL_W=16), then 1 more → `total` wraps to 0. A drop coinciding with `clr_overflow` → `overflow`=1.
- `pending`=5, assert `reset` for 1 cycle → `pending`=0, `total`=0, `evt_valid`=0, `overflow`=0. `tog_in` high at release → exactly one event.

Source files
------------

// File: rtl/toggle_event_decoder.sv
// Receive side of the toggle-event link: synchronizes a level-toggle line,
// turns each transition into one queued event and hands events out over valid/ready.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOTAL_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tog_in,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [CNT_W-1:0]   pending,
    output logic [TOTAL_W-1:0] total,
    output logic               overflow,
    input  logic               clr_overflow
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last;
    logic                   det;
    logic                   acc;
    logic                   full;
    logic                   drop;
    logic [CNT_W-1:0]       pending_nxt;

    // A detection and an acceptance in the same cycle cancel, so a full queue
    // only drops when nothing is leaving it.
    always_comb begin
        det         = sync_q[SYNC_STAGES-1] ^ last;
        acc         = evt_valid & evt_ready;
        full        = (pending == PEND_MAX);
        drop        = det & ~acc & full;
        pending_nxt = pending;
        if (det && !acc && !full) begin
            pending_nxt = pending + 1'b1;
        end else if (!det && acc) begin
            pending_nxt = pending - 1'b1;
        end
    end

    // evt_valid is registered from the next pending value so it never
    // depends combinationally on evt_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            last      <= 1'b0;
            pending   <= '0;
            evt_valid <= 1'b0;
            total     <= '0;
            overflow  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], tog_in};
            last      <= sync_q[SYNC_STAGES-1];
            pending   <= pending_nxt;
            evt_valid <= (pending_nxt != '0);
            if (det) begin
                total <= total + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
